// File: rtl/hms_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hms_mode_ctrl
//  Purpose  : Pushbutton debounce plus CLOCK/SETUP/ALARM mode, digit-position
//             and count-enable control for an hour/min/sec clock.
//             Optional macro HMS_AUTO_REPEAT_EN adds hold-to-repeat on sw2.
//  Revision : 1.0  initial release
// ============================================================================
module hms_mode_ctrl #(
    parameter logic [19:0] DEB_CYC    = 20'd500000,
    parameter logic [31:0] BLINK_HALF = 32'd12500000,
    parameter logic [31:0] RPT_DLY    = 32'd25000000,
    parameter logic [31:0] RPT_PER    = 32'd5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_tick_1hz,
    input  logic       i_sec_max,
    input  logic       i_min_max,
    output logic [1:0] o_mode,
    output logic [1:0] o_position,
    output logic [2:0] o_time_inc,
    output logic [2:0] o_alarm_inc,
    output logic       o_blink
);

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_SETUP = 2'd1,
        MODE_ALARM = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2,
        POS_RSVD = 2'd3
    } pos_t;

    localparam logic [19:0] c_deb_max   = DEB_CYC - 20'd1;
    localparam logic [31:0] c_blink_max = BLINK_HALF - 32'd1;

    logic [2:0] w_sw_raw;
    logic [2:0] w_press;

    assign w_sw_raw = {i_sw2, i_sw1, i_sw0};

    // Per switch: synchronizer, stability counter and falling-edge event.
    // r_armed is cleared by reset and only set after a stable release, so a
    // button held through reset cannot produce an event when it is let go.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        logic        r_meta;
        logic        r_sync;
        logic        r_samp;
        logic [19:0] r_cnt;
        logic        r_level;
        logic        r_armed;
        logic        r_press;
        logic        w_stable;

        assign w_stable = (r_cnt == c_deb_max) && (r_sync == r_samp);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_meta  <= 1'b1;
                r_sync  <= 1'b1;
                r_samp  <= 1'b1;
                r_cnt   <= '0;
                r_level <= 1'b1;
                r_armed <= 1'b0;
                r_press <= 1'b0;
            end else begin
                r_meta  <= w_sw_raw[gi];
                r_sync  <= r_meta;
                r_samp  <= r_sync;
                r_press <= 1'b0;
                if (r_sync != r_samp) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_deb_max) begin
                    r_cnt <= r_cnt + 20'd1;
                end
                if (w_stable) begin
                    r_level <= r_sync;
                    if (r_sync) begin
                        r_armed <= 1'b1;
                    end else if (r_level && r_armed) begin
                        r_press <= 1'b1;
                    end
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    mode_t      r_mode;
    mode_t      w_mode_nxt;
    pos_t       r_pos;
    pos_t       w_pos_nxt;
    logic [2:0] r_time_inc;
    logic [2:0] r_alarm_inc;
    logic [2:0] w_time_nxt;
    logic [2:0] w_alarm_nxt;
    logic [2:0] w_tick_inc;
    logic [2:0] w_pos_onehot;
    logic       w_setting;
    logic       w_sw2_evt;
    logic       w_ev_mode;
    logic       w_ev_pos;
    logic       w_ev_inc;
    logic       r_blink;
    logic [31:0] r_blink_cnt;

    assign w_setting  = (r_mode == MODE_SETUP) || (r_mode == MODE_ALARM);
    // sw0 outranks sw1, which outranks sw2
    assign w_ev_mode  = w_press[0];
    assign w_ev_pos   = w_press[1] & ~w_press[0] & w_setting;
    assign w_ev_inc   = w_sw2_evt & ~w_press[0] & ~w_press[1] & w_setting;

    assign w_tick_inc = {i_tick_1hz & i_sec_max & i_min_max,
                         i_tick_1hz & i_sec_max,
                         i_tick_1hz};

    always_comb begin
        w_pos_onehot = 3'b000;
        case (r_pos)
            POS_SEC:  w_pos_onehot = 3'b001;
            POS_MIN:  w_pos_onehot = 3'b010;
            POS_HOUR: w_pos_onehot = 3'b100;
            default:  w_pos_onehot = 3'b000;
        endcase
    end

`ifdef HMS_AUTO_REPEAT_EN
    localparam logic [31:0] c_rpt_dly_max = RPT_DLY - 32'd1;
    localparam logic [31:0] c_rpt_per_max = RPT_PER - 32'd1;

    logic        w_sw2_held;
    logic        w_rpt_fire;
    logic        r_rpt_act;
    logic        r_rpt_per_ph;
    logic [31:0] r_rpt_cnt;

    assign w_sw2_held = ~g_sw[2].r_level;
    assign w_rpt_fire = r_rpt_act &&
                        (r_rpt_cnt == (r_rpt_per_ph ? c_rpt_per_max : c_rpt_dly_max));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_act    <= 1'b0;
            r_rpt_per_ph <= 1'b0;
            r_rpt_cnt    <= '0;
        end else if (!w_sw2_held || !w_setting || w_ev_mode || w_ev_pos) begin
            r_rpt_act    <= 1'b0;
            r_rpt_per_ph <= 1'b0;
            r_rpt_cnt    <= '0;
        end else if (w_ev_inc && !r_rpt_act) begin
            r_rpt_act    <= 1'b1;
            r_rpt_per_ph <= 1'b0;
            r_rpt_cnt    <= '0;
        end else if (w_rpt_fire) begin
            r_rpt_per_ph <= 1'b1;
            r_rpt_cnt    <= '0;
        end else if (r_rpt_act) begin
            r_rpt_cnt    <= r_rpt_cnt + 32'd1;
        end
    end

    assign w_sw2_evt = w_press[2] | w_rpt_fire;
`else
    assign w_sw2_evt = w_press[2];

    // Repeat timing parameters stay on the interface for build compatibility.
    if (RPT_DLY == 32'd0 && RPT_PER == 32'd0) begin : g_rpt_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_CLOCK;
            r_pos       <= POS_SEC;
            r_time_inc  <= 3'b000;
            r_alarm_inc <= 3'b000;
        end else begin
            r_mode      <= w_mode_nxt;
            r_pos       <= w_pos_nxt;
            r_time_inc  <= w_time_nxt;
            r_alarm_inc <= w_alarm_nxt;
        end
    end

    always_comb begin
        w_mode_nxt  = r_mode;
        w_pos_nxt   = r_pos;
        w_time_nxt  = 3'b000;
        w_alarm_nxt = 3'b000;
        case (r_mode)
            MODE_CLOCK: begin
                w_time_nxt = w_tick_inc;
                if (w_ev_mode) w_mode_nxt = MODE_SETUP;
            end
            MODE_SETUP: begin
                if (w_ev_mode) w_mode_nxt = MODE_ALARM;
                if (w_ev_inc)  w_time_nxt = w_pos_onehot;
            end
            MODE_ALARM: begin
                w_time_nxt = w_tick_inc;
                if (w_ev_mode) w_mode_nxt = MODE_CLOCK;
                if (w_ev_inc)  w_alarm_nxt = w_pos_onehot;
            end
            default: w_mode_nxt = MODE_CLOCK;
        endcase

        if (w_mode_nxt != r_mode) begin
            w_pos_nxt = POS_SEC;
        end else if (w_ev_pos) begin
            case (r_pos)
                POS_SEC: w_pos_nxt = POS_MIN;
                POS_MIN: w_pos_nxt = POS_HOUR;
                default: w_pos_nxt = POS_SEC;
            endcase
        end else if (r_pos == POS_RSVD) begin
            w_pos_nxt = POS_SEC;
        end
    end

    // Blink phase restarts on every mode change so each mode begins lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if ((w_mode_nxt != r_mode) || !w_setting) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == c_blink_max) begin
            r_blink     <= ~r_blink;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + 32'd1;
        end
    end

    assign o_mode      = r_mode;
    assign o_position  = r_pos;
    assign o_time_inc  = r_time_inc;
    assign o_alarm_inc = r_alarm_inc;
    assign o_blink     = r_blink;

endmodule
`default_nettype wire
